dot_collector: RTL and testbench

Consumes the player position produced each game tick by the player movement stage and owns the live dot map. It clears the dot under the player, accumulates score, and tracks remaining dots. It also raises level-clear. Its `tilemap_dots` output feeds the player movement stage, the ghost stages and the renderer.

---
 rtl/dot_collector_pkg.sv | 18 +
 rtl/dot_score_accum.sv | 52 +++++
 rtl/dot_collector.sv | 153 +++++++++++++++
 tb/tb_dot_collector.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_collector_pkg.sv
// Shared tile geometry, screen size and the dot_collector state encoding.
package dot_collector_pkg;

   localparam int tile_size    = 20;
   localparam int tile_col_num = 32;
   localparam int tile_row_num = 24;
   localparam int WIDTH        = 640;
   localparam int HEIGHT       = 480;

   localparam logic [15:0] BCD_MAX = 16'h9999;

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      RUN     = 2'd1,
      CLEARED = 2'd2
   } state_t;

endpackage

// File: rtl/dot_score_accum.sv
// Saturating score accumulator: plain binary by default, packed 4-digit BCD
// when DOT_SCORE_BCD_EN is defined (SCORE_W must then be 16).
module dot_score_accum
   import dot_collector_pkg::*;
#(
   parameter int POINTS  = 10,
   parameter int SCORE_W = 16
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic               add,
   output logic [SCORE_W-1:0] score
);

   logic [SCORE_W-1:0] score_next;

`ifdef DOT_SCORE_BCD_EN
   localparam logic [7:0] POINTS_BCD = 8'(((POINTS / 10) * 16) + (POINTS % 10));

   logic [SCORE_W-1:0] addend;
   logic [SCORE_W-1:0] sum;
   logic [4:0]         carry;

   assign addend   = {8'h00, POINTS_BCD};
   assign carry[0] = 1'b0;

   // Ripple decimal carry across the four packed digits.
   for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      logic [4:0] raw;
      assign raw          = {1'b0, score[4*gi +: 4]} + {1'b0, addend[4*gi +: 4]} + {4'd0, carry[gi]};
      assign carry[gi+1]  = (raw > 5'd9);
      assign sum[4*gi +: 4] = carry[gi+1] ? (raw[3:0] + 4'd6) : raw[3:0];
   end

   assign score_next = carry[4] ? BCD_MAX : sum;
`else
   logic [SCORE_W:0] sum_wide;

   assign sum_wide   = {1'b0, score} + (SCORE_W+1)'(POINTS);
   assign score_next = sum_wide[SCORE_W] ? '1 : sum_wide[SCORE_W-1:0];
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         score <= '0;
      end else if (add) begin
         score <= score_next;
      end
   end

endmodule

// File: rtl/dot_collector.sv
// Live dot map owner: loads the level map, clears dots under the player
// through a two-stage pipeline and scores them; DOT_SCORE_BCD_EN selects BCD score.
module dot_collector
   import dot_collector_pkg::*;
#(
   parameter int COLS    = tile_col_num,
   parameter int ROWS    = tile_row_num,
   parameter int TILE    = tile_size,
   parameter int X_W     = $clog2(WIDTH),
   parameter int Y_W     = $clog2(HEIGHT),
   parameter int POINTS  = 10,
   parameter int SCORE_W = 16
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [X_W-1:0]       x,
   input  logic [Y_W-1:0]       y,
   input  logic [COLS*ROWS-1:0] init_dots,
   input  logic                 restart,
   output logic [COLS*ROWS-1:0] tilemap_dots,
   output logic [SCORE_W-1:0]   score,
   output logic [9:0]           dots_left,
   output logic                 dot_eaten,
   output logic                 level_clear,
   output logic                 ready
);

   localparam int N     = COLS * ROWS;
   localparam int IDX_W = $clog2(N);

   localparam logic [X_W:0] X_LIM = (X_W+1)'(COLS * TILE);
   localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(ROWS * TILE);

   state_t state, state_next;

   logic [IDX_W-1:0] scan_idx;
   logic             scan_last;
   logic [9:0]       load_total;

   logic             in_range;
   logic [IDX_W-1:0] tile_col;
   logic [IDX_W-1:0] tile_row;
   logic [IDX_W-1:0] idx_calc;
   logic [IDX_W-1:0] idx_q;
   logic             idx_v;

   logic             eat;
   logic             add;

   assign scan_last  = (scan_idx == IDX_W'(N - 1));
   assign load_total = dots_left + {9'd0, init_dots[scan_idx]};

   // Stage 1: tile index of the current pixel position.
   assign in_range = ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
   assign tile_col = IDX_W'(x / X_W'(TILE));
   assign tile_row = IDX_W'(y / Y_W'(TILE));
   assign idx_calc = IDX_W'(COLS) * tile_row + tile_col;

   // Stage 2: eat only while running; a coincident restart suppresses scoring.
   assign eat = (state == RUN) && idx_v && tilemap_dots[idx_q];
   assign add = eat && !restart;

   assign ready       = (state != LOAD);
   assign level_clear = (state == CLEARED);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= LOAD;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         LOAD: begin
            if (scan_last) begin
               state_next = (load_total == 10'd0) ? CLEARED : RUN;
            end
         end
         RUN: begin
            if (eat && dots_left == 10'd1) begin
               state_next = CLEARED;
            end
         end
         CLEARED: begin
            state_next = CLEARED;
         end
         default: begin
            state_next = LOAD;
         end
      endcase
      if (restart) begin
         state_next = LOAD;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx_q <= '0;
         idx_v <= 1'b0;
      end else begin
         idx_q <= in_range ? idx_calc : '0;
         idx_v <= in_range && (state == RUN) && !restart;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scan_idx     <= '0;
         tilemap_dots <= '0;
         dots_left    <= '0;
         dot_eaten    <= 1'b0;
      end else if (restart) begin
         scan_idx  <= '0;
         dots_left <= '0;
         dot_eaten <= 1'b0;
      end else begin
         dot_eaten <= 1'b0;
         case (state)
            LOAD: begin
               if (scan_idx == '0) begin
                  tilemap_dots <= init_dots;
               end
               dots_left <= load_total;
               scan_idx  <= scan_last ? '0 : scan_idx + 1'b1;
            end
            RUN: begin
               if (eat) begin
                  tilemap_dots[idx_q] <= 1'b0;
                  dots_left           <= dots_left - 10'd1;
                  dot_eaten           <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   dot_score_accum #(
      .POINTS  (POINTS),
      .SCORE_W (SCORE_W)
   ) u_accum (
      .clk   (clk),
      .reset (reset),
      .add   (add),
      .score (score)
   );

endmodule

// File: tb/tb_dot_collector.sv
// Randomized scoreboard bench for dot_collector: a tile-level model predicts
// every dot eaten; a negedge monitor checks each dot_eaten pulse against it.
module tb_dot_collector;

   localparam int COLS = 32;
   localparam int ROWS = 24;
   localparam int TILE = 20;
   localparam int N    = COLS * ROWS;
   localparam int PTS  = 99;
`ifdef DOT_SCORE_BCD_EN
   localparam int SW   = 16;
   localparam int SMAX = 9999;
`else
   localparam int SW   = 11;
   localparam int SMAX = 2047;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [9:0]    x;
   logic [8:0]    y;
   logic [N-1:0]  init_dots;
   logic          restart;
   logic [N-1:0]  tilemap_dots;
   logic [SW-1:0] score;
   logic [9:0]    dots_left;
   logic          dot_eaten;
   logic          level_clear;
   logic          ready;

   dot_collector #(
      .POINTS  (PTS),
      .SCORE_W (SW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .x            (x),
      .y            (y),
      .init_dots    (init_dots),
      .restart      (restart),
      .tilemap_dots (tilemap_dots),
      .score        (score),
      .dots_left    (dots_left),
      .dot_eaten    (dot_eaten),
      .level_clear  (level_clear),
      .ready        (ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      int idx;
      int sc;
      int dl;
      int cy;
   } exp_t;

   exp_t         exp_q[$];
   int           passed = 0;
   int           total  = 0;
   int           cyc    = 0;
   logic [N-1:0] mmap   = '0;
   int           mdots  = 0;
   int           mscore = 0;
   bit           mrun   = 0;
   bit           pend_v = 0;
   int           pend_idx = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int score_enc(input int s);
`ifdef DOT_SCORE_BCD_EN
      return ((s / 1000) % 10) * 4096 + ((s / 100) % 10) * 256 + ((s / 10) % 10) * 16 + (s % 10);
`else
      return s;
`endif
   endfunction

   function automatic logic [N-1:0] gen_map(input int ndots);
      logic [N-1:0] m = '0;
      if (ndots > 0) begin
         m[0]   = 1'b1;
         m[N-1] = 1'b1;
         while ($countones(m) < ndots) m[$urandom_range(0, N-1)] = 1'b1;
      end
      return m;
   endfunction

   function automatic int tx(input int t);
      return (t % COLS) * TILE + int'($urandom_range(0, TILE-1));
   endfunction

   function automatic int ty(input int t);
      return (t / COLS) * TILE + int'($urandom_range(0, TILE-1));
   endfunction

   function automatic int find_set();
      int start = int'($urandom_range(0, N-1));
      for (int i = 0; i < N; i++) begin
         if (mmap[(start + i) % N]) return (start + i) % N;
      end
      return -1;
   endfunction

   task automatic chk(input string name, input int act, input int want);
      total++;
      if (act == want) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, want);
   endtask

   task automatic chk_map(input string name, input logic [N-1:0] want);
      int diff = -1;
      total++;
      if (tilemap_dots === want) begin
         passed++;
      end else begin
         for (int i = N-1; i >= 0; i--) if (tilemap_dots[i] !== want[i]) diff = i;
         $display("FAIL %s: got %0d dots set, expected %0d (first differing tile %0d)",
                  name, $countones(tilemap_dots), $countones(want), diff);
      end
   endtask

   // Model: a dot present on a reached tile is eaten, scored and counted.
   task automatic apply(input int idx);
      if (mrun && mdots > 0 && mmap[idx]) begin
         mmap[idx] = 1'b0;
         mdots--;
         mscore = (mscore + PTS > SMAX) ? SMAX : mscore + PTS;
         exp_q.push_back('{idx, score_enc(mscore), mdots, cyc + 1});
      end
   endtask

   // A position takes effect unless the following cycle carries a restart.
   task automatic step(input int px, input int py, input bit rst);
      @(posedge clk);
      #1;
      if (pend_v && !rst) apply(pend_idx);
      pend_v  = 0;
      x       = 10'(px);
      y       = 9'(py);
      restart = rst;
      if (rst) begin
         mrun = 0;
      end else if (mrun && px < COLS*TILE && py < ROWS*TILE) begin
         pend_v   = 1;
         pend_idx = (py / TILE) * COLS + px / TILE;
      end
   endtask

   task automatic wait_ready(input int want_n);
      int n   = 0;
      bit got = 0;
      for (int i = 1; i <= 2000 && !got; i++) begin
         step(1000, 500, 0);
         if (ready) begin
            got = 1;
            n   = i;
         end
      end
      chk("load_cycles", n, want_n);
      mrun  = 1;
      mmap  = init_dots;
      mdots = $countones(init_dots);
      chk("load_dots_left", int'(dots_left), mdots);
      chk_map("load_map", mmap);
      chk("load_level_clear", int'(level_clear), (mdots == 0) ? 1 : 0);
      chk("load_score", int'(score), score_enc(mscore));
   endtask

   task automatic drain_check(input string tag);
      repeat (3) step(1000, 500, 0);
      chk({tag, "_missing_eats"}, exp_q.size(), 0);
      chk({tag, "_score"}, int'(score), score_enc(mscore));
      chk({tag, "_dots_left"}, int'(dots_left), mdots);
      chk({tag, "_level_clear"}, int'(level_clear), (mdots == 0) ? 1 : 0);
      chk({tag, "_ready"}, int'(ready), 1);
      chk_map({tag, "_map"}, mmap);
   endtask

   task automatic walk(input int steps);
      int s = 0;
      while (s < steps) begin
         int r = int'($urandom_range(0, 9));
         int t = find_set();
         if (r == 0) begin
            if ($urandom_range(0, 1) == 1) step(int'($urandom_range(640, 1023)), int'($urandom_range(0, 511)), 0);
            else step(int'($urandom_range(0, 639)), int'($urandom_range(480, 511)), 0);
            s++;
         end else if (r <= 2 || t < 0) begin
            step(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 0);
            s++;
         end else begin
            int hold = int'($urandom_range(1, 4));
            int px   = tx(t);
            int py   = ty(t);
            repeat (hold) step(px, py, 0);
            s += hold;
         end
      end
   endtask

   task automatic sweep();
      for (int i = 0; i < N; i++) if (mmap[i]) step(tx(i), ty(i), 0);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (reset === 1'b1 && dot_eaten === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_eat: dot_eaten=1 at cycle %0d, expected no pulse (score %0d)", cyc, score);
         end else begin
            e = exp_q.pop_front();
            if (int'(score) == e.sc && int'(dots_left) == e.dl && tilemap_dots[e.idx] == 1'b0 && cyc == e.cy) begin
               passed++;
               $display("eat tile %0d cycle %0d score %0d dots_left %0d", e.idx, cyc, score, dots_left);
            end else begin
               $display("FAIL eat_tile_%0d: got score %0d dots_left %0d bit %0d cycle %0d, expected score %0d dots_left %0d bit 0 cycle %0d",
                        e.idx, score, dots_left, tilemap_dots[e.idx], cyc, e.sc, e.dl, e.cy);
            end
         end
      end
   end

   initial begin
      logic [N-1:0] new_map;
      reset     = 1'b0;
      restart   = 1'b0;
      x         = 10'd1000;
      y         = 9'd500;
      init_dots = gen_map(30);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", int'(ready), 0);
      chk("rst_score", int'(score), 0);
      chk("rst_dots_left", int'(dots_left), 0);
      chk("rst_dot_eaten", int'(dot_eaten), 0);
      chk("rst_level_clear", int'(level_clear), 0);
      chk_map("rst_map", '0);

      // Abort a load part-way with an asynchronous reset.
      @(negedge clk) reset = 1'b1;
      repeat (100) step(1000, 500, 0);
      #3 reset = 1'b0;
      #1;
      chk("abort_dots_left", int'(dots_left), 0);
      chk("abort_ready", int'(ready), 0);
      chk_map("abort_map", '0);
      @(negedge clk) reset = 1'b1;
      wait_ready(768);

      for (int lev = 1; lev <= 6; lev++) begin
         walk((lev == 2) ? 20 : 150);
         drain_check("walk");
         new_map = gen_map((lev == 5) ? 0 : 30);
         if (lev == 2 && mdots > 0) begin
            // Restart lands on the same edge as an eat: the eat must vanish.
            int t = find_set();
            init_dots = new_map;
            step(tx(t), ty(t), 0);
            step(1000, 500, 1);
         end else begin
            sweep();
            drain_check("clear");
            if (lev == 1) begin
               for (int i = 0; i < N; i++) if (init_dots[i]) step(tx(i), ty(i), 0);
               drain_check("frozen");
            end
            if (lev < 6) begin
               init_dots = new_map;
               step(1000, 500, 1);
            end
         end
         if (lev < 6) begin
            step(1000, 500, 0);
            chk("restart_ready", int'(ready), 0);
            chk("restart_level_clear", int'(level_clear), 0);
            chk("restart_dot_eaten", int'(dot_eaten), 0);
            chk("restart_dots_left", int'(dots_left), 0);
            chk("restart_score", int'(score), score_enc(mscore));
            wait_ready(768);
         end
      end

      chk("score_saturated", int'(score), score_enc(SMAX));
      chk("final_queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
